// File: rtl/pipe_stage_reg_if.sv
// Valid/ready word channel between two pipeline stages.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, a one-entry skid buffer,
// a synchronous flush and a wrapping count of completed output transfers.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      CNT_W   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                i_che,
    input  logic                i_rst_n,
    input  logic                i_flush,
    pipe_stage_reg_if.slave     s_in,
    pipe_stage_reg_if.master    m_out,
    output logic [1:0]          o_occupancy,
    output logic [CNT_W-1:0]    o_xfer_cnt
);

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_main;
    logic [WIDTH-1:0]   r_skid;
    logic [WIDTH-1:0]   w_main_nxt;
    logic [WIDTH-1:0]   w_skid_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic [OCC_W-1:0]   r_occ;
    logic [OCC_W-1:0]   w_occ_nxt;
    logic [CNT_W-1:0]   r_xfer_cnt;
    logic               w_in_fire;
    logic               w_out_fire;

    assign w_in_fire  = s_in.valid & r_in_ready;
    assign w_out_fire = r_out_valid & m_out.ready;

    // Handshake flags and occupancy are kept as flops so no input reaches an output.
    always_ff @(posedge i_che or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= RST_VAL;
            r_skid      <= RST_VAL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_occ       <= w_occ_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = RST_VAL;
            w_skid_nxt  = RST_VAL;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = s_in.data;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt  = s_in.data;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = s_in.data;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Upstream is stalled here; only a drain can move the stage.
                    if (w_out_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end

        w_in_ready_nxt  = (w_state_nxt != ST_FULL);
        w_out_valid_nxt = (w_state_nxt != ST_EMPTY);
        unique case (w_state_nxt)
            ST_ONE:  w_occ_nxt = OCC_W'(1);
            ST_FULL: w_occ_nxt = OCC_W'(2);
            default: w_occ_nxt = OCC_W'(0);
        endcase
    end

    // Flush does not clear the count: a word sampled downstream is a completed transfer.
    always_ff @(posedge i_che or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_out_fire) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        end
    end

    assign s_in.ready   = r_in_ready;
    assign m_out.valid  = r_out_valid;
    assign m_out.data   = r_main;
    assign o_occupancy  = r_occ;
    assign o_xfer_cnt   = r_xfer_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed checks of pipe_stage_reg against a queue-based model;
// two instances share stimulus, one with a 3-bit counter to exercise wrap.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        tb_flush;
    logic        tb_valid;
    logic [31:0] tb_data;
    logic        tb_oready;

    logic [1:0]  occ_a;
    logic [1:0]  occ_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;

    pipe_stage_reg_if #(.WIDTH(32)) if_a_in ();
    pipe_stage_reg_if #(.WIDTH(32)) if_a_out ();
    pipe_stage_reg_if #(.WIDTH(32)) if_b_in ();
    pipe_stage_reg_if #(.WIDTH(32)) if_b_out ();

    assign if_a_in.valid  = tb_valid;
    assign if_a_in.data   = tb_data;
    assign if_a_out.ready = tb_oready;
    assign if_b_in.valid  = tb_valid;
    assign if_b_in.data   = tb_data;
    assign if_b_out.ready = tb_oready;

    pipe_stage_reg #(.WIDTH(32), .CNT_W(16), .RST_VAL(32'h0)) dut_a (
        .i_che       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (tb_flush),
        .s_in        (if_a_in),
        .m_out       (if_a_out),
        .o_occupancy (occ_a),
        .o_xfer_cnt  (cnt_a)
    );

    pipe_stage_reg #(.WIDTH(32), .CNT_W(3), .RST_VAL(32'h0)) dut_b (
        .i_che       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (tb_flush),
        .s_in        (if_b_in),
        .m_out       (if_b_out),
        .o_occupancy (occ_b),
        .o_xfer_cnt  (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: FIFO of held words (capacity 2), the word last presented, and a transfer tally.
    logic [31:0] mq[$];
    logic [31:0] m_data;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_ready;
        logic [31:0] e_valid;
        logic [31:0] e_occ;
        e_ready = (mq.size() < 2) ? 32'd1 : 32'd0;
        e_valid = (mq.size() > 0) ? 32'd1 : 32'd0;
        e_occ   = 32'(mq.size());
        chk("in_ready_a",  32'(if_a_in.ready),  e_ready);
        chk("out_valid_a", 32'(if_a_out.valid), e_valid);
        chk("out_data_a",  if_a_out.data,       m_data);
        chk("occupancy_a", 32'(occ_a),          e_occ);
        chk("xfer_cnt_a",  32'(cnt_a),          m_cnt % 65536);
        chk("in_ready_b",  32'(if_b_in.ready),  e_ready);
        chk("out_valid_b", 32'(if_b_out.valid), e_valid);
        chk("out_data_b",  if_b_out.data,       m_data);
        chk("occupancy_b", 32'(occ_b),          e_occ);
        chk("xfer_cnt_b",  32'(cnt_b),          m_cnt % 8);
    endtask

    task automatic model_reset();
        mq.delete();
        m_data = 32'h0;
        m_cnt  = 0;
    endtask

    // One clock: apply inputs, predict from the pre-edge model, check just after the edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
        bit in_fire;
        bit out_fire;
        tb_valid  = v;
        tb_data   = d;
        tb_oready = r;
        tb_flush  = f;
        in_fire  = v && (mq.size() < 2);
        out_fire = r && (mq.size() > 0);
        @(posedge clk);
        if (out_fire) m_cnt++;
        if (f) begin
            mq.delete();
            m_data = 32'h0;
        end else begin
            if (out_fire) void'(mq.pop_front());
            if (in_fire)  mq.push_back(d);
            if (mq.size() > 0) m_data = mq[0];
        end
        #1;
        check_all();
    endtask

    initial begin
        rst_n     = 1'b0;
        tb_flush  = 1'b0;
        tb_valid  = 1'b0;
        tb_data   = 32'h0;
        tb_oready = 1'b0;
        model_reset();
        #7;
        check_all();
        rst_n = 1'b1;

        // Back-to-back streaming at full throughput
        for (int i = 1; i <= 16; i++) cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_cnt", 32'(cnt_a), 32'd16);

        // Backpressure: third word refused until the skid drains
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Simultaneous accept and drain while holding one word
        cycle(1'b1, 32'h5, 1'b0, 1'b0);
        cycle(1'b1, 32'h6, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with a full stage and an incoming word
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        // Flush coinciding with an output transfer still counts it
        cycle(1'b1, 32'h44, 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 1'b1, 1'b1);

        // Asynchronous reset with two words held
        cycle(1'b1, 32'h66, 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap on the 3-bit instance, flush mid-sequence keeps the count
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
            if (i == 4) cycle(1'b1, 32'h2FF, 1'b0, 1'b1);
            if (i == 4) cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("wrap_cnt_b", 32'(cnt_b), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
